// File: rtl/i2s_tdm_tx.sv
// i2s_tdm_tx: parametrised I2S / left-justified / TDM serial audio transmitter.
// Frames enter a small frame FIFO over a valid/ready stream and are serialised
// MSB-first, one slot per channel, on sclk/lrclk/sdout.
//
// Stream handshake: a frame is taken on any clk edge where s_tvalid && s_tready.
// s_tready is a combinational !full and never depends on s_tvalid or on a pop
// in the same cycle.
module i2s_tdm_tx #(
    parameter int DATA_W     = 16,
    parameter int SLOT_W     = 16,
    parameter int CHANNELS   = 2,
    parameter int CLK_DIV    = 2,
    parameter int MODE       = 0,
    parameter int FIFO_DEPTH = 4,
    parameter int UNDER_HOLD = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic [CHANNELS*DATA_W-1:0]     s_tdata,
    input  logic                           s_tvalid,
    output logic                           s_tready,
    output logic                           sclk,
    output logic                           lrclk,
    output logic                           sdout,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_level,
    output logic                           underrun,
    output logic [15:0]                    underrun_cnt
);

    localparam int FRAME_W = CHANNELS * DATA_W;
    localparam int TOT_W   = CHANNELS * SLOT_W;
    localparam int BIT_W   = (TOT_W > 1) ? $clog2(TOT_W) : 1;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LVL_W   = $clog2(FIFO_DEPTH) + 1;

    // Lay a frame out in transmit order: slot 0 at the top, each slot holding
    // its channel MSB-first followed by zero padding.
    function automatic logic [TOT_W-1:0] fmt(input logic [FRAME_W-1:0] f);
        logic [TOT_W-1:0] r;
        r = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            r[TOT_W-1-k*SLOT_W -: DATA_W] = f[k*DATA_W +: DATA_W];
        end
        return r;
    endfunction

    logic [FRAME_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic [FRAME_W-1:0] last_q, last_d;
    logic [TOT_W-1:0]   shift_q, shift_d;
    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic               running_q, running_d;
    logic               sclk_q, sclk_d, lrclk_q, lrclk_d, sdout_q, sdout_d;
    logic               underrun_q, underrun_d;
    logic [15:0]        ucnt_q, ucnt_d;

    logic               full, push, pop, div_wrap, fall, last_bit;
    logic               frame_start, advance;
    logic [FRAME_W-1:0] src;
    logic [TOT_W-1:0]   load_val;

    // Next-state logic for FIFO, divider, bit counter and serial outputs.
    always_comb begin
        full        = (level_q == LVL_W'(FIFO_DEPTH));
        push        = s_tvalid && !full;
        div_wrap    = (div_cnt_q == DIV_W'(CLK_DIV - 1));
        fall        = running_q && div_wrap && sclk_q;
        last_bit    = (bit_cnt_q == BIT_W'(TOT_W - 1));
        frame_start = en && (!running_q || (fall && last_bit));
        advance     = en && fall && !last_bit;
        pop         = frame_start && (level_q != '0);
        src         = pop ? mem_q[rd_ptr_q] : ((UNDER_HOLD != 0) ? last_q : '0);
        load_val    = fmt(src);

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        last_d     = last_q;
        shift_d    = shift_q;
        div_cnt_d  = div_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        running_d  = running_q;
        sclk_d     = sclk_q;
        lrclk_d    = lrclk_q;
        sdout_d    = sdout_q;
        underrun_d = 1'b0;
        ucnt_d     = ucnt_q;

        if (push) begin
            wr_ptr_d = (wr_ptr_q == AW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == AW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            last_d   = mem_q[rd_ptr_q];
        end
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        if (!en) begin
            // Idle: everything serial goes quiet, partial frame is dropped.
            running_d = 1'b0;
            div_cnt_d = '0;
            bit_cnt_d = '0;
            sclk_d    = 1'b0;
            lrclk_d   = 1'b0;
            sdout_d   = 1'b0;
            shift_d   = '0;
        end else if (frame_start) begin
            running_d = 1'b1;
            div_cnt_d = '0;
            bit_cnt_d = '0;
            sclk_d    = 1'b0;
            lrclk_d   = 1'b0;
            shift_d   = load_val;
            // I2S mode sends the bit held over from the previous sclk period.
            sdout_d   = (MODE != 0) ? load_val[TOT_W-1] : shift_q[TOT_W-1];
            if (!pop) begin
                underrun_d = 1'b1;
                ucnt_d     = (ucnt_q == 16'hFFFF) ? ucnt_q : ucnt_q + 16'd1;
            end
        end else begin
            div_cnt_d = div_wrap ? '0 : div_cnt_q + 1'b1;
            if (div_wrap) begin
                sclk_d = !sclk_q;
            end
            if (advance) begin
                bit_cnt_d = bit_cnt_q + 1'b1;
                shift_d   = shift_q << 1;
                sdout_d   = (MODE != 0) ? shift_q[TOT_W-2] : shift_q[TOT_W-1];
                lrclk_d   = (bit_cnt_d >= BIT_W'(TOT_W / 2));
            end
        end
    end

    // Frame storage; contents need no reset because level/pointers gate reads.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= s_tdata;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            last_q     <= '0;
            shift_q    <= '0;
            div_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            running_q  <= 1'b0;
            sclk_q     <= 1'b0;
            lrclk_q    <= 1'b0;
            sdout_q    <= 1'b0;
            underrun_q <= 1'b0;
            ucnt_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            last_q     <= last_d;
            shift_q    <= shift_d;
            div_cnt_q  <= div_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            running_q  <= running_d;
            sclk_q     <= sclk_d;
            lrclk_q    <= lrclk_d;
            sdout_q    <= sdout_d;
            underrun_q <= underrun_d;
            ucnt_q     <= ucnt_d;
        end
    end

    assign s_tready     = !full;
    assign sclk         = sclk_q;
    assign lrclk        = lrclk_q;
    assign sdout        = sdout_q;
    assign fifo_level   = level_q;
    assign underrun     = underrun_q;
    assign underrun_cnt = ucnt_q;

endmodule

// File: tb/tb_i2s_tdm_tx.sv
// Bench for i2s_tdm_tx: two instances share one input stream (same 32-bit
// frame width) but differ in format, so both I2S delay and left-justified
// timing, stereo and 4-slot TDM, zero-fill and hold underrun are exercised.
// Expected outputs come from a time-based model: clk count since the run
// started gives sclk period and phase, from which every output follows.
module tb_i2s_tdm_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        s_tvalid;
  logic [31:0] s_tdata;

  logic        s_tready_a, sclk_a, lrclk_a, sdout_a, underrun_a;
  logic [2:0]  fifo_level_a;
  logic [15:0] underrun_cnt_a;
  logic        s_tready_b, sclk_b, lrclk_b, sdout_b, underrun_b;
  logic [2:0]  fifo_level_b;
  logic [15:0] underrun_cnt_b;

  // clock / reset
  always #5 clk = ~clk;

  i2s_tdm_tx #(.DATA_W(16), .SLOT_W(16), .CHANNELS(2), .CLK_DIV(2),
               .MODE(1), .FIFO_DEPTH(4), .UNDER_HOLD(0)) dut_a (
    .clk(clk), .rst(rst), .en(en), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
    .s_tready(s_tready_a), .sclk(sclk_a), .lrclk(lrclk_a), .sdout(sdout_a),
    .fifo_level(fifo_level_a), .underrun(underrun_a), .underrun_cnt(underrun_cnt_a)
  );

  i2s_tdm_tx #(.DATA_W(8), .SLOT_W(12), .CHANNELS(4), .CLK_DIV(1),
               .MODE(0), .FIFO_DEPTH(4), .UNDER_HOLD(1)) dut_b (
    .clk(clk), .rst(rst), .en(en), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
    .s_tready(s_tready_b), .sclk(sclk_b), .lrclk(lrclk_b), .sdout(sdout_b),
    .fifo_level(fifo_level_b), .underrun(underrun_b), .underrun_cnt(underrun_cnt_b)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // reference model (index 0 = dut_a, 1 = dut_b)
  int m_cd[2]   = '{2, 1};
  int m_dw[2]   = '{16, 8};
  int m_sw[2]   = '{16, 12};
  int m_ch[2]   = '{2, 4};
  int m_mode[2] = '{1, 0};
  int m_uh[2]   = '{0, 1};

  int          m_t[2];
  bit          m_run[2];
  logic [31:0] m_cur[2], m_prv[2], m_last[2];
  int          m_ucnt[2];
  bit          e_sclk[2], e_lr[2], e_sd[2], e_und[2];

  logic [31:0] exp_q_a[$];
  logic [31:0] exp_q_b[$];

  function automatic int qsize(input int inst);
    return (inst == 0) ? exp_q_a.size() : exp_q_b.size();
  endfunction

  function automatic logic [31:0] qpop(input int inst);
    if (inst == 0) return exp_q_a.pop_front();
    return exp_q_b.pop_front();
  endfunction

  task automatic qpush(input int inst, input logic [31:0] d);
    if (inst == 0) exp_q_a.push_back(d);
    else exp_q_b.push_back(d);
  endtask

  // Bit n of a frame in transmit order.
  function automatic bit fbit(input int inst, input logic [31:0] f, input int n);
    int k;
    int j;
    k = n / m_sw[inst];
    j = n % m_sw[inst];
    if (j >= m_dw[inst]) return 1'b0;
    return f[k*m_dw[inst] + m_dw[inst] - 1 - j];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_run[i] = 0; m_t[i] = 0; m_cur[i] = '0; m_prv[i] = '0; m_last[i] = '0;
      m_ucnt[i] = 0; e_sclk[i] = 0; e_lr[i] = 0; e_sd[i] = 0; e_und[i] = 0;
    end
    exp_q_a.delete();
    exp_q_b.delete();
  endtask

  task automatic model_step(input int inst, input bit en_s, input bit push_s, input logic [31:0] d_s);
    int p;
    int ph;
    int n;
    int tot;
    tot = m_ch[inst] * m_sw[inst];
    e_und[inst] = 0;
    if (!en_s) begin
      m_run[inst] = 0;
      e_sclk[inst] = 0; e_lr[inst] = 0; e_sd[inst] = 0;
    end else begin
      if (!m_run[inst]) begin
        m_run[inst] = 1;
        m_t[inst] = 0;
      end else begin
        m_t[inst]++;
      end
      p  = m_t[inst] / (2 * m_cd[inst]);
      ph = m_t[inst] % (2 * m_cd[inst]);
      n  = p % tot;
      if (ph == 0 && n == 0) begin
        m_prv[inst] = m_cur[inst];
        if (qsize(inst) > 0) begin
          m_cur[inst]  = qpop(inst);
          m_last[inst] = m_cur[inst];
        end else begin
          m_cur[inst] = (m_uh[inst] != 0) ? m_last[inst] : 32'h0;
          e_und[inst] = 1;
          if (m_ucnt[inst] < 65535) m_ucnt[inst]++;
        end
      end
      e_sclk[inst] = (ph >= m_cd[inst]);
      e_lr[inst]   = (n >= tot / 2);
      if (m_mode[inst] != 0)  e_sd[inst] = fbit(inst, m_cur[inst], n);
      else if (p == 0)        e_sd[inst] = 1'b0;
      else if (n == 0)        e_sd[inst] = fbit(inst, m_prv[inst], tot - 1);
      else                    e_sd[inst] = fbit(inst, m_cur[inst], n - 1);
    end
    if (push_s) qpush(inst, d_s);
  endtask

  task automatic check_outputs();
    check("sclk_a",  sclk_a,  e_sclk[0]);
    check("lrclk_a", lrclk_a, e_lr[0]);
    check("sdout_a", sdout_a, e_sd[0]);
    check("under_a", underrun_a, e_und[0]);
    check("ucnt_a",  underrun_cnt_a, m_ucnt[0]);
    check("level_a", fifo_level_a, exp_q_a.size());
    check("sclk_b",  sclk_b,  e_sclk[1]);
    check("lrclk_b", lrclk_b, e_lr[1]);
    check("sdout_b", sdout_b, e_sd[1]);
    check("under_b", underrun_b, e_und[1]);
    check("ucnt_b",  underrun_cnt_b, m_ucnt[1]);
    check("level_b", fifo_level_b, exp_q_b.size());
  endtask

  // capture of dut_a serial data on sclk rises, for the directed frame check
  bit          cap_en = 0;
  int          cap_n = 0;
  logic [31:0] cap_a = '0;

  // driver: one clk cycle with the current inputs, then model update + checks
  task automatic tick();
    bit          en_s;
    bit          v_s;
    bit          pa;
    bit          pb;
    bit          sclk_prev;
    logic [31:0] d_s;
    en_s = en; v_s = s_tvalid; d_s = s_tdata;
    check("ready_a", s_tready_a, exp_q_a.size() < 4);
    check("ready_b", s_tready_b, exp_q_b.size() < 4);
    pa = v_s && (exp_q_a.size() < 4);
    pb = v_s && (exp_q_b.size() < 4);
    sclk_prev = sclk_a;
    @(posedge clk);
    #1;
    model_step(0, en_s, pa, d_s);
    model_step(1, en_s, pb, d_s);
    check_outputs();
    if (cap_en && !sclk_prev && sclk_a && cap_n < 32) begin
      cap_a = {cap_a[30:0], sdout_a};
      cap_n++;
    end
  endtask

  task automatic push_frame(input logic [31:0] d);
    s_tvalid = 1'b1;
    s_tdata  = d;
    tick();
    s_tvalid = 1'b0;
  endtask

  // asynchronous reset in the middle of whatever is running
  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    check("rst_ready_a", s_tready_a, 1);
    check("rst_ready_b", s_tready_b, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; s_tvalid = 1'b0; s_tdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    check("rst_ready_a", s_tready_a, 1);
    check("rst_ready_b", s_tready_b, 1);
    rst = 1'b0;
    tick();

    // directed stereo frame, then underrun frames
    push_frame(32'hA5C31234);
    cap_en = 1;
    en = 1'b1;
    repeat (3 * 128) tick();
    cap_en = 0;
    check("frame_a_bits", cap_a, 32'h1234A5C3);
    en = 1'b0;
    tick();

    // fill past full with en low: fifth frame is held off
    for (int i = 0; i < 5; i++) push_frame($urandom);
    check("full_level_a", fifo_level_a, 4);
    check("full_ready_a", s_tready_a, 0);
    en = 1'b1;
    repeat (300) tick();
    en = 1'b0;
    tick();

    // randomized runs: pushes while idle, sparse pushes while running,
    // random en drops, occasional asynchronous reset mid-run
    for (int it = 0; it < 12; it++) begin
      int npush;
      int nrun;
      int rst_at;
      repeat ($urandom_range(1, 3)) tick();
      npush = $urandom_range(0, 6);
      for (int i = 0; i < npush; i++) begin
        push_frame($urandom);
        if ($urandom_range(0, 3) == 0) tick();
      end
      en = 1'b1;
      nrun = $urandom_range(40, 600);
      rst_at = (it % 4 == 3) ? $urandom_range(5, nrun - 1) : -1;
      for (int c = 0; c < nrun; c++) begin
        if (c == rst_at) do_reset();
        s_tvalid = ($urandom_range(0, 39) == 0);
        s_tdata  = $urandom;
        tick();
      end
      s_tvalid = 1'b0;
      en = 1'b0;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
